// File: rtl/vr_conditioner.sv
// VR crank input conditioner: synchronises the raw comparator output, detects
// rising edges, rejects noise edges with an adaptive lockout window, and emits
// a clean single-cycle tooth pulse together with the measured tooth period.
module vr_conditioner #(
  parameter int PERIOD_W      = 24,
  parameter int SYNC_STAGES   = 2,
  parameter int LOCKOUT_SHIFT = 2,
  parameter int MIN_LOCKOUT   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vrin_raw,
  input  logic                enable,
  output logic                tooth,
  output logic [PERIOD_W-1:0] tooth_period,
  output logic                period_valid,
  output logic                stalled,
  output logic [7:0]          reject_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
  localparam logic [PERIOD_W-1:0] MIN_LOCK = PERIOD_W'(MIN_LOCKOUT);
  localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic                  tooth_q, tooth_d;
  logic [PERIOD_W-1:0]   tooth_period_q, tooth_period_d;
  logic                  period_valid_q, period_valid_d;
  logic                  stalled_q, stalled_d;
  logic [7:0]            reject_count_q, reject_count_d;

  logic                  rise;
  logic                  timeout;
  logic                  accept;
  logic                  reject;
  logic [PERIOD_W-1:0]   shifted;
  logic [PERIOD_W-1:0]   lockout;

  // Synchroniser chain plus the prev flop used for rising-edge detection
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], vrin_raw};
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Lockout window, timeout detection and accept/reject decision
  always_comb begin
    shifted = tooth_period_q >> LOCKOUT_SHIFT;
    lockout = (shifted > MIN_LOCK) ? shifted : MIN_LOCK;
    timeout = (state_q != IDLE) && (cnt_q == CNT_MAX);
    accept  = 1'b0;
    reject  = 1'b0;
    if (enable) begin
      // A timeout demotes the current edge to an IDLE edge, which is always taken
      if (timeout || state_q == IDLE) begin
        accept = rise;
      end else if (state_q == FIRST) begin
        accept = rise && (cnt_q >= MIN_LOCK);
        reject = rise && (cnt_q <  MIN_LOCK);
      end else begin
        accept = rise && (cnt_q >= lockout);
        reject = rise && (cnt_q <  lockout);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (timeout) begin
      state_d = rise ? FIRST : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = FIRST;
        FIRST:   if (accept) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: tooth pulse, period measurement, status and reject counter
  always_comb begin
    cnt_d          = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    tooth_d        = accept;
    tooth_period_d = tooth_period_q;
    period_valid_d = period_valid_q;
    stalled_d      = stalled_q;
    reject_count_d = reject_count_q;
    if (accept) begin
      cnt_d = CNT_ONE;
    end
    if (!enable || timeout) begin
      tooth_period_d = '0;
      period_valid_d = 1'b0;
      stalled_d      = 1'b1;
    end else if (accept && state_q != IDLE) begin
      tooth_period_d = cnt_q;
      period_valid_d = 1'b1;
      stalled_d      = 1'b0;
    end
    if (reject && reject_count_q != 8'hFF) begin
      reject_count_d = reject_count_q + 8'd1;
    end
  end

  // Datapath and synchroniser registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q         <= '0;
      prev_q         <= 1'b0;
      cnt_q          <= '0;
      tooth_q        <= 1'b0;
      tooth_period_q <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b1;
      reject_count_q <= '0;
    end else begin
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      cnt_q          <= cnt_d;
      tooth_q        <= tooth_d;
      tooth_period_q <= tooth_period_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
      reject_count_q <= reject_count_d;
    end
  end

  assign tooth        = tooth_q;
  assign tooth_period = tooth_period_q;
  assign period_valid = period_valid_q;
  assign stalled      = stalled_q;
  assign reject_count = reject_count_q;

endmodule

// File: tb/tb_vr_conditioner.sv
// Bench for vr_conditioner: two instances (24-bit and 8-bit period counters)
// share stimulus; a rule-level model is checked every cycle, and literal
// expectations at key points pin the model.
module tb_vr_conditioner;

  localparam int SYNC  = 2;
  localparam int SHIFT = 2;
  localparam int MINL  = 16;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic vrin_raw = 1'b0;
  logic enable   = 1'b1;

  logic        tooth_a, valid_a, stalled_a;
  logic [23:0] period_a;
  logic [7:0]  rej_a;
  logic        tooth_b, valid_b, stalled_b;
  logic [7:0]  period_b;
  logic [7:0]  rej_b;

  int tests = 0;
  int fails = 0;
  int shown = 0;

  always #5 clk = ~clk;

  vr_conditioner #(.PERIOD_W(24), .SYNC_STAGES(2), .LOCKOUT_SHIFT(2), .MIN_LOCKOUT(16)) u_a (
    .clk(clk), .reset_n(reset_n), .vrin_raw(vrin_raw), .enable(enable),
    .tooth(tooth_a), .tooth_period(period_a), .period_valid(valid_a),
    .stalled(stalled_a), .reject_count(rej_a)
  );

  vr_conditioner #(.PERIOD_W(8), .SYNC_STAGES(2), .LOCKOUT_SHIFT(2), .MIN_LOCKOUT(16)) u_b (
    .clk(clk), .reset_n(reset_n), .vrin_raw(vrin_raw), .enable(enable),
    .tooth(tooth_b), .tooth_period(period_b), .period_valid(valid_b),
    .stalled(stalled_b), .reject_count(rej_b)
  );

  // Model state: raw sample history, mode (0 idle, 1 first, 2 run),
  // cycles since last accepted edge (saturating), and the expected outputs.
  typedef struct {
    logic [7:0] h;
    int         mode;
    int         el;
    bit         tooth;
    int         period;
    bit         valid;
    bit         stalled;
    int         rej;
  } mstate_t;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.h = '0; s.mode = 0; s.el = 0; s.tooth = 1'b0; s.period = 0;
    s.valid = 1'b0; s.stalled = 1'b1; s.rej = 0;
    return s;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input logic raw, input logic en, input int maxv);
    mstate_t n;
    bit      e;
    bit      to;
    int      cur;
    int      lock;
    n       = s;
    // rise seen now is the raw rise sampled SYNC clocks ago
    e       = s.h[SYNC-1] && !s.h[SYNC];
    n.h     = {s.h[6:0], raw};
    n.tooth = 1'b0;
    n.el    = (s.el < maxv) ? s.el + 1 : maxv;
    lock    = s.period >> SHIFT;
    if (lock < MINL) lock = MINL;
    if (!en) begin
      n.mode = 0; n.valid = 1'b0; n.stalled = 1'b1; n.period = 0;
    end else begin
      to  = (s.mode != 0) && (s.el >= maxv);
      cur = to ? 0 : s.mode;
      if (to) begin
        n.mode = 0; n.valid = 1'b0; n.stalled = 1'b1; n.period = 0;
      end
      if (e) begin
        if (cur == 0) begin
          n.tooth = 1'b1; n.el = 1; n.mode = 1;
        end else if ((cur == 1 && s.el >= MINL) || (cur == 2 && s.el >= lock)) begin
          n.tooth = 1'b1; n.el = 1; n.mode = 2;
          n.period = s.el; n.valid = 1'b1; n.stalled = 1'b0;
        end else if (n.rej < 255) begin
          n.rej = n.rej + 1;
        end
      end
    end
    return n;
  endfunction

  mstate_t ma, mb;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma <= m_reset();
      mb <= m_reset();
    end else begin
      ma <= m_step(ma, vrin_raw, enable, 32'hFF_FFFF);
      mb <= m_step(mb, vrin_raw, enable, 255);
    end
  end

  task automatic cmp(input string nm, input logic t, input logic [31:0] per, input logic v,
                     input logic st, input logic [31:0] rj, input mstate_t m);
    tests++;
    if (t !== m.tooth || per !== 32'(m.period) || v !== m.valid || st !== m.stalled || rj !== 32'(m.rej)) begin
      fails++;
      if (shown < 40) begin
        shown++;
        $display("FAIL %s @%0t actual tooth=%b per=%0d valid=%b stalled=%b rej=%0d required tooth=%b per=%0d valid=%b stalled=%b rej=%0d",
                 nm, $time, t, per, v, st, rj, m.tooth, m.period, m.valid, m.stalled, m.rej);
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(posedge clk) begin
    #1;
    cmp("model_a", tooth_a, {8'h0, period_a}, valid_a, stalled_a, {24'h0, rej_a}, ma);
    cmp("model_b", tooth_b, {24'h0, period_b}, valid_b, stalled_b, {24'h0, rej_b}, mb);
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic lit_reset(input string nm);
    lit({nm, "_tooth_a"},  {31'h0, tooth_a}, 0);
    lit({nm, "_per_a"},    {8'h0, period_a}, 0);
    lit({nm, "_valid_a"},  {31'h0, valid_a}, 0);
    lit({nm, "_stall_a"},  {31'h0, stalled_a}, 1);
    lit({nm, "_rej_a"},    {24'h0, rej_a}, 0);
    lit({nm, "_stall_b"},  {31'h0, stalled_b}, 1);
    lit({nm, "_rej_b"},    {24'h0, rej_b}, 0);
  endtask

  // One rise, high for h cycles, next rise p cycles later; call at a negedge
  task automatic tg(input int p, input int h);
    vrin_raw = 1'b1;
    repeat (h) @(negedge clk);
    vrin_raw = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  // Short rise, then a g_len-cycle glitch g_off cycles after it
  task automatic gg(input int p, input int g_off, input int g_len);
    vrin_raw = 1'b1;
    repeat (5) @(negedge clk);
    vrin_raw = 1'b0;
    repeat (g_off - 5) @(negedge clk);
    vrin_raw = 1'b1;
    repeat (g_len) @(negedge clk);
    vrin_raw = 1'b0;
    repeat (p - g_off - g_len) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    lit_reset("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: first tooth latency, then steady 100-cycle teeth
    vrin_raw = 1'b1;
    @(posedge clk); #1 lit("lat_e1", {31'h0, tooth_a}, 0);
    @(posedge clk); #1 lit("lat_e2", {31'h0, tooth_a}, 0);
    @(posedge clk); #1 lit("lat_e3", {31'h0, tooth_a}, 1);
    lit("first_valid", {31'h0, valid_a}, 0);
    lit("first_stall", {31'h0, stalled_a}, 1);
    @(posedge clk); #1 lit("lat_e4", {31'h0, tooth_a}, 0);
    @(negedge clk);
    repeat (46) @(negedge clk);
    vrin_raw = 1'b0;
    repeat (50) @(negedge clk);
    tg(100, 50);
    lit("t1_per_a", {8'h0, period_a}, 100);
    lit("t1_valid_a", {31'h0, valid_a}, 1);
    lit("t1_stall_a", {31'h0, stalled_a}, 0);
    lit("t1_per_b", {24'h0, period_b}, 100);
    for (int i = 0; i < 3; i++) begin
      tg(100, 50);
      lit("t1_per_run", {8'h0, period_a}, 100);
    end

    // 2: glitch 10 cycles after a tooth is rejected
    gg(100, 10, 3);
    lit("t2_rej", {24'h0, rej_a}, 1);
    lit("t2_per", {8'h0, period_a}, 100);
    tg(100, 50);
    lit("t2_per_next", {8'h0, period_a}, 100);

    // 3: missing-tooth gap 100/300/100, then glitch 40 after the long tooth
    tg(300, 50);
    lit("t3_per_100", {8'h0, period_a}, 100);
    gg(100, 40, 3);
    lit("t3_per_300", {8'h0, period_a}, 300);
    lit("t3_rej", {24'h0, rej_a}, 2);
    tg(100, 50);
    lit("t3_per_after", {8'h0, period_a}, 100);

    // 4: long silence times out the 8-bit instance
    tg(400, 50);
    lit("t4_stall_b", {31'h0, stalled_b}, 1);
    lit("t4_valid_b", {31'h0, valid_b}, 0);
    lit("t4_per_b", {24'h0, period_b}, 0);
    lit("t4_valid_a", {31'h0, valid_a}, 1);
    tg(100, 50);
    lit("t4_per_a_400", {8'h0, period_a}, 400);
    lit("t4_first_valid_b", {31'h0, valid_b}, 0);
    lit("t4_first_stall_b", {31'h0, stalled_b}, 1);
    tg(100, 50);
    lit("t4_per_b_100", {24'h0, period_b}, 100);
    lit("t4_valid_b_1", {31'h0, valid_b}, 1);

    // 5: disable for 20 cycles across an edge
    enable = 1'b0;
    repeat (5) @(negedge clk);
    vrin_raw = 1'b1;
    repeat (15) @(negedge clk);
    lit("t5_stall", {31'h0, stalled_a}, 1);
    lit("t5_valid", {31'h0, valid_a}, 0);
    lit("t5_per", {8'h0, period_a}, 0);
    lit("t5_rej", {24'h0, rej_a}, 2);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    vrin_raw = 1'b0;
    repeat (50) @(negedge clk);
    lit("t5_still_stall", {31'h0, stalled_a}, 1);
    tg(100, 50);
    lit("t5_first_valid", {31'h0, valid_a}, 0);
    tg(100, 50);
    lit("t5_second_valid", {31'h0, valid_a}, 1);
    lit("t5_second_per", {8'h0, period_a}, 100);

    // 6: asynchronous reset between teeth, then a glitch storm saturates rejects
    repeat (30) @(negedge clk);
    lit("t6_pre_per", {8'h0, period_a}, 100);
    #2 reset_n = 1'b0;
    #1 lit_reset("t6_async");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      vrin_raw = 1'b1;
      repeat (2) @(negedge clk);
      vrin_raw = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    lit("t6_rej_sat_a", {24'h0, rej_a}, 255);
    lit("t6_rej_sat_b", {24'h0, rej_b}, 255);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
